// File: rtl/demux_seq_pkg.sv
// demux_seq_pkg: shared constants, state type and helper for the demux
// sequencer slice.
//   NUM_CH            number of demux channels
//   SEL_W             width of a channel index / demux select
//   demux_seq_state_t sequencer state encoding
//   first_ch()        lowest enabled channel in a mask (0 if mask is empty)
// Optional feature macro used elsewhere in this slice: DEMUX_SEQ_CONT_EN.
package demux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } demux_seq_state_t;

  // Scan from the top down so the lowest set bit is the last one written.
  function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = {SEL_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = SEL_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/demux_seq_next_ch.sv
// demux_seq_next_ch: combinational lookup of the next enabled channel strictly
// above the current one.
// Ports:
//   mask    in  NUM_CH  enabled channels
//   wrap    in  1       (DEMUX_SEQ_CONT_EN only) if nothing remains above cur,
//                       return the lowest enabled channel instead
//   cur     in  SEL_W   current channel index
//   next_ch out SEL_W   next channel index (equals cur when valid is low)
//   valid   out 1       a next channel exists
module demux_seq_next_ch
  import demux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
`ifdef DEMUX_SEQ_CONT_EN
  input  logic              wrap,
`endif
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next_ch,
  output logic              valid
);

  // Priority search: descending loop leaves the lowest qualifying index.
  always_comb begin
    next_ch = cur;
    valid   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        next_ch = SEL_W'(i);
        valid   = 1'b1;
      end else begin
        next_ch = next_ch;
      end
    end
`ifdef DEMUX_SEQ_CONT_EN
    if (!valid && wrap && (mask != {NUM_CH{1'b0}})) begin
      next_ch = first_ch(mask);
      valid   = 1'b1;
    end else begin
      valid = valid;
    end
`endif
  end

endmodule

// File: rtl/demux_seq_ctrl.sv
// demux_seq_ctrl: sweeps the enabled channels of a 1-to-4 demux in ascending
// order. Each channel gets a settle interval (gate low, select stable) and a
// dwell interval (gate high). All outputs are registered.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          sweep request (IDLE only) / unconditional stop
//   chan_mask, dwell_len  latched on an accepted start; dwell 0 acts as 1
//   cont                  continuous sweeps (only with DEMUX_SEQ_CONT_EN)
//   demux_sel, demux_gate demux select and data enable
//   busy                  state is not IDLE
//   chan_done, done_chan  channel completion pulse and its index
//   sweep_done            end-of-sweep pulse
module demux_seq_ctrl
  import demux_seq_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic [CNT_W-1:0]  dwell_len,
`ifdef DEMUX_SEQ_CONT_EN
  input  logic              cont,
`endif
  output logic [SEL_W-1:0]  demux_sel,
  output logic              demux_gate,
  output logic              busy,
  output logic              chan_done,
  output logic [SEL_W-1:0]  done_chan,
  output logic              sweep_done
);

  // Settle and dwell share one down-counter wide enough for either load.
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CW    = (CNT_W > SET_W) ? CNT_W : SET_W;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  demux_seq_state_t  state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [NUM_CH-1:0] mask_r, mask_s;
  logic [CNT_W-1:0]  dwell_r, dwell_s;
  logic [SEL_W-1:0]  sel_r, sel_s;
  logic              gate_r, gate_s;
  logic              busy_r, busy_s;
  logic              chan_done_r, chan_done_s;
  logic [SEL_W-1:0]  done_chan_r, done_chan_s;
  logic              sweep_done_r, sweep_done_s;
  logic [SEL_W-1:0]  nxt_ch_s;
  logic              nxt_valid_s;

  demux_seq_next_ch u_next_ch (
    .mask    (mask_r),
`ifdef DEMUX_SEQ_CONT_EN
    .wrap    (cont),
`endif
    .cur     (sel_r),
    .next_ch (nxt_ch_s),
    .valid   (nxt_valid_s)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that they can be registered alongside the state.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    mask_s       = mask_r;
    dwell_s      = dwell_r;
    sel_s        = sel_r;
    gate_s       = 1'b0;
    chan_done_s  = 1'b0;
    done_chan_s  = done_chan_r;
    sweep_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (abort) begin
          state_s = IDLE;
        end else if (start) begin
          mask_s  = chan_mask;
          dwell_s = (dwell_len == {CNT_W{1'b0}}) ? CNT_W'(1) : dwell_len;
          if (chan_mask != {NUM_CH{1'b0}}) begin
            state_s = SETTLE;
            sel_s   = first_ch(chan_mask);
            cnt_s   = SETTLE_LOAD;
          end else begin
            sweep_done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_ONE) begin
          state_s = DWELL;
          cnt_s   = CW'(dwell_r);
          gate_s  = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      DWELL: begin
        if (abort) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_ONE) begin
          chan_done_s = 1'b1;
          done_chan_s = sel_r;
          if (nxt_valid_s) begin
            state_s = SETTLE;
            sel_s   = nxt_ch_s;
            cnt_s   = SETTLE_LOAD;
            // A next channel at or below the current one means a wrap.
            sweep_done_s = (nxt_ch_s <= sel_r);
          end else begin
            state_s      = IDLE;
            sweep_done_s = 1'b1;
          end
        end else begin
          cnt_s  = cnt_r - CNT_ONE;
          gate_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, counter, latched configuration and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      mask_r       <= {NUM_CH{1'b0}};
      dwell_r      <= {CNT_W{1'b0}};
      sel_r        <= {SEL_W{1'b0}};
      gate_r       <= 1'b0;
      busy_r       <= 1'b0;
      chan_done_r  <= 1'b0;
      done_chan_r  <= {SEL_W{1'b0}};
      sweep_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      mask_r       <= mask_s;
      dwell_r      <= dwell_s;
      sel_r        <= sel_s;
      gate_r       <= gate_s;
      busy_r       <= busy_s;
      chan_done_r  <= chan_done_s;
      done_chan_r  <= done_chan_s;
      sweep_done_r <= sweep_done_s;
    end
  end

  assign demux_sel  = sel_r;
  assign demux_gate = gate_r;
  assign busy       = busy_r;
  assign chan_done  = chan_done_r;
  assign done_chan  = done_chan_r;
  assign sweep_done = sweep_done_r;

endmodule
